// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: extends the instruction immediate to XLEN and precomputes pc+imm,
// behind a valid/ready handshake with a main output register and a one-entry skid register.
module imm_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_target,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] target;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] imm_ext;
  logic            illegal;
  entry_t          in_entry;
  entry_t          main_q, skid_q;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            main_load_in, main_load_skid, skid_load;
  logic            accept, out_fire;

  // Sized casts of signed operands sign-extend; unsigned operands zero-extend.
  always_comb begin
    imm_ext = '0;
    illegal = 1'b0;
    case (in_imm_src)
      3'b000: imm_ext = XLEN'($signed(in_instr[31:20]));
      3'b001: imm_ext = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b010: imm_ext = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                        in_instr[11:8], 1'b0}));
      3'b011: imm_ext = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                        in_instr[30:21], 1'b0}));
      3'b100: imm_ext = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'b101: imm_ext = XLEN'(in_instr[19:15]);
      3'b110: imm_ext = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
      default: begin
        imm_ext = '0;
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_entry.instr   = in_instr;
    in_entry.pc      = in_pc;
    in_entry.imm     = imm_ext;
    in_entry.target  = in_pc + PC_W'($signed(imm_ext));
    in_entry.illegal = illegal;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // Main slot is free this edge; the skid entry is older than any new input.
      if (skid_valid_q) begin
        main_load_skid = 1'b1;
        main_valid_d   = 1'b1;
        skid_valid_d   = 1'b0;
      end else begin
        main_load_in = accept;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (main_load_skid) begin
      main_q <= skid_q;
    end else if (main_load_in) begin
      main_q <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= in_entry;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an RV32 and an RV64 instance share the same stimulus;
// inputs change and outputs are sampled on the falling clock edge.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        rdy32, val32, ill32;
  logic [31:0] ins32, opc32, imm32, tgt32;
  logic        rdy64, val64, ill64;
  logic [31:0] ins64;
  logic [63:0] opc64, imm64, tgt64;

  int checks = 0;
  int errors = 0;

  assign pc64 = {32'h0, pc32};

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(pc32), .in_imm_src(in_imm_src), .out_valid(val32),
    .out_ready(out_ready), .out_instr(ins32), .out_pc(opc32), .out_imm(imm32),
    .out_target(tgt32), .out_illegal(ill32)
  );

  imm_decode_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(pc64), .in_imm_src(in_imm_src), .out_valid(val64),
    .out_ready(out_ready), .out_instr(ins64), .out_pc(opc64), .out_imm(imm64),
    .out_target(tgt64), .out_illegal(ill64)
  );

  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] pc);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    pc32       = pc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'hFFFF_FFFF; in_imm_src = 3'b000; pc32 = 32'h0;
    #2;
    checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", val32); end
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", rdy32); end
    checks++; if (imm32 !== 32'h0) begin errors++; $display("FAIL rst_imm got %h want 0", imm32); end
    checks++; if (tgt32 !== 32'h0) begin errors++; $display("FAIL rst_target got %h want 0", tgt32); end
    checks++; if (opc32 !== 32'h0 || ins32 !== 32'h0 || ill32 !== 1'b0) begin
      errors++; $display("FAIL rst_data got pc %h instr %h ill %b want 0", opc32, ins32, ill32);
    end
    checks++; if (val64 !== 1'b0 || imm64 !== 64'h0) begin
      errors++; $display("FAIL rst_64 got valid %b imm %h want 0", val64, imm64);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_type();
    drive(32'hFFF0_0093, 3'b000, 32'h0);
    @(negedge clk); idle();
    checks++; if (val32 !== 1'b1) begin errors++; $display("FAIL i_valid got %b want 1", val32); end
    checks++; if (imm32 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL i_imm got %h want ffffffff", imm32);
    end
    checks++; if (tgt32 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL i_target got %h want ffffffff", tgt32);
    end
    checks++; if (ins32 !== 32'hFFF0_0093) begin
      errors++; $display("FAIL i_instr got %h want fff00093", ins32);
    end
    checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL i64_imm got %h want ffffffffffffffff", imm64);
    end
    @(negedge clk);
    checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL i_drain got %b want 0", val32); end
  endtask

  task automatic test_b_s_z();
    drive(32'hFE00_0EE3, 3'b010, 32'h100);
    @(negedge clk);
    checks++; if (imm32 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL b_imm got %h want fffffffc", imm32);
    end
    checks++; if (tgt32 !== 32'h0000_00FC || opc32 !== 32'h100) begin
      errors++; $display("FAIL b_target got %h pc %h want fc pc 100", tgt32, opc32);
    end
    drive(32'h8000_0000, 3'b001, 32'h0);
    @(negedge clk);
    checks++; if (imm32 !== 32'hFFFF_F800) begin
      errors++; $display("FAIL s_imm got %h want fffff800", imm32);
    end
    drive(32'hFFFF_FFFF, 3'b101, 32'h0);
    @(negedge clk); idle();
    checks++; if (imm32 !== 32'h1F || imm64 !== 64'h1F) begin
      errors++; $display("FAIL z_imm got %h / %h want 1f", imm32, imm64);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(32'h0080_006F, 3'b011, 32'h200);
    @(negedge clk);
    checks++; if (val32 !== 1'b1 || imm32 !== 32'h8 || tgt32 !== 32'h208) begin
      errors++; $display("FAIL j_out got v %b imm %h tgt %h want 1 8 208", val32, imm32, tgt32);
    end
    drive(32'h1234_50B7, 3'b100, 32'h204);
    @(negedge clk); idle();
    checks++; if (val32 !== 1'b1 || imm32 !== 32'h1234_5000 || tgt32 !== 32'h1234_5204) begin
      errors++;
      $display("FAIL u_out got v %b imm %h tgt %h want 1 12345000 12345204", val32, imm32, tgt32);
    end
    checks++; if (imm64 !== 64'h1234_5000) begin
      errors++; $display("FAIL u64_imm got %h want 12345000", imm64);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'h0010_0093, 3'b000, 32'h10);
    @(negedge clk);
    checks++; if (rdy32 !== 1'b1 || val32 !== 1'b1 || imm32 !== 32'h1) begin
      errors++; $display("FAIL bp_a got rdy %b v %b imm %h want 1 1 1", rdy32, val32, imm32);
    end
    drive(32'h0020_0093, 3'b000, 32'h14);
    @(negedge clk);
    checks++; if (rdy32 !== 1'b0 || imm32 !== 32'h1 || opc32 !== 32'h10) begin
      errors++; $display("FAIL bp_full got rdy %b imm %h pc %h want 0 1 10", rdy32, imm32, opc32);
    end
    drive(32'h0030_0093, 3'b000, 32'h18);
    @(negedge clk);
    checks++; if (rdy32 !== 1'b0 || val32 !== 1'b1 || imm32 !== 32'h1 || tgt32 !== 32'h11) begin
      errors++; $display("FAIL bp_hold got rdy %b v %b imm %h tgt %h want 0 1 1 11",
                         rdy32, val32, imm32, tgt32);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (val32 !== 1'b1 || imm32 !== 32'h2 || opc32 !== 32'h14 || rdy32 !== 1'b1) begin
      errors++; $display("FAIL bp_b got v %b imm %h pc %h rdy %b want 1 2 14 1",
                         val32, imm32, opc32, rdy32);
    end
    @(negedge clk); idle();
    checks++; if (val32 !== 1'b1 || imm32 !== 32'h3 || tgt32 !== 32'h1B) begin
      errors++; $display("FAIL bp_c got v %b imm %h tgt %h want 1 3 1b", val32, imm32, tgt32);
    end
    @(negedge clk);
    checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", val32); end
  endtask

  task automatic test_xlen64();
    drive(32'h8000_00B7, 3'b100, 32'h0);
    @(negedge clk);
    checks++; if (imm64 !== 64'hFFFF_FFFF_8000_0000 || tgt64 !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("FAIL lui64 got imm %h tgt %h want ffffffff80000000", imm64, tgt64);
    end
    checks++; if (imm32 !== 32'h8000_0000) begin
      errors++; $display("FAIL lui32 got %h want 80000000", imm32);
    end
    drive(32'h0210_9093, 3'b110, 32'h0);
    @(negedge clk); idle();
    checks++; if (imm64 !== 64'h21) begin errors++; $display("FAIL sh64 got %h want 21", imm64); end
    checks++; if (imm32 !== 32'h1) begin errors++; $display("FAIL sh32 got %h want 1", imm32); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    drive(32'hFFFF_FFFF, 3'b111, 32'h40);
    @(negedge clk);
    checks++; if (val32 !== 1'b1 || ill32 !== 1'b1 || imm32 !== 32'h0 || tgt32 !== 32'h40) begin
      errors++; $display("FAIL ill got v %b ill %b imm %h tgt %h want 1 1 0 40",
                         val32, ill32, imm32, tgt32);
    end
    drive(32'hFFF0_0093, 3'b000, 32'h0);
    @(negedge clk); idle();
    checks++; if (ill32 !== 1'b0 || ill64 !== 1'b0) begin
      errors++; $display("FAIL ill_clear got %b/%b want 0", ill32, ill64);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h0010_0093, 3'b000, 32'h10);
    @(negedge clk);
    drive(32'h0020_0093, 3'b000, 32'h14);
    @(negedge clk);
    checks++; if (rdy32 !== 1'b0 || val32 !== 1'b1) begin
      errors++; $display("FAIL fl_full got rdy %b v %b want 0 1", rdy32, val32);
    end
    flush = 1'b1;
    drive(32'h0030_0093, 3'b000, 32'h18);
    @(negedge clk);
    flush = 1'b0; idle();
    checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1 || val64 !== 1'b0) begin
      errors++; $display("FAIL fl_clear got v %b rdy %b v64 %b want 0 1 0", val32, rdy32, val64);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL fl_gone got %b want 0", val32); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(32'h0010_0093, 3'b000, 32'h10);
    @(negedge clk);
    drive(32'h0020_0093, 3'b000, 32'h14);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (val32 !== 1'b0 || rdy32 !== 1'b1 || imm32 !== 32'h0 || opc32 !== 32'h0) begin
      errors++; $display("FAIL arst got v %b rdy %b imm %h pc %h want 0 1 0 0",
                         val32, rdy32, imm32, opc32);
    end
    idle();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (val32 !== 1'b0) begin errors++; $display("FAIL arst_gone got %b want 0", val32); end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_s_z();
    test_back_to_back();
    test_backpressure();
    test_xlen64();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined immediate-decode stage between fetch/decode and execute. Accepts instruction, PC and immediate-format select through a valid/ready handshake.
- Outputs the sign-extended or zero-extended immediate at XLEN, plus a precomputed PC-relative target (pc + imm).
- Successor to the combinational immediate extender. Adds parametrised XLEN (RV32/RV64), CSR-zimm and shift-amount formats, an illegal-format flag, and a 2-entry skid buffer so back-pressure from execute does not create a combinational ready path.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- PC_W, XLEN, width of the PC passthrough and of the target adder.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_instr  input  32  raw instruction.
- in_pc  input  PC_W  instruction PC.
- in_imm_src  input  3  immediate format select.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32  registered instruction.
- out_pc  output  PC_W  registered PC.
- out_imm  output  XLEN  extended immediate.
- out_target  output  PC_W  out_pc + out_imm, truncated to PC_W (wraps).
- out_illegal  output  1  format select 111 was used.

Behaviour:
- Format encoding, all fields taken from in_instr:
  - 000 I: sign-extend instr[31:20].
  - 001 S: sign-extend {instr[31:25], instr[11:7]}.
  - 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 101 Z: zero-extend instr[19:15] (CSR zimm).
  - 110 SH: zero-extend instr[24:20] when XLEN=32; zero-extend instr[25:20] when XLEN=64.
  - 111: imm = 0, out_illegal = 1. The entry still flows through the stage; it is never dropped.
- Immediate and target are computed combinationally on the input side and registered. Latency is 1 cycle from acceptance to out_valid when the output slot is free.
- Storage:
  - Output register (main) plus one skid register.
  - in_ready = ~skid_valid (registered, no combinational path from out_ready).
- Handshake: a transfer occurs when valid & ready are both high on a rising edge.
  - Accept while main is empty, or while main is transferring out: data goes to main.
  - Accept while main is full and stalled (out_ready=0): data goes to skid, skid_valid=1.
  - Main transfers out and skid is valid: skid moves to main and skid_valid clears the same cycle. A simultaneous new accept cannot occur, because in_ready was 0.
- Ordering: strictly FIFO; throughput is 1 per cycle with out_ready held at 1.
- out_valid must not drop, and out_* must stay stable, while out_valid=1 and out_ready=0.
- flush:
  - Next edge: main_valid=0 and skid_valid=0.
  - An in_valid in the same cycle is discarded.
  - Flush has priority over every other event.
- Reset:
  - rst_n low immediately clears main_valid and skid_valid, and zeroes all data registers. out_valid=0, in_ready=1, out_imm=0, out_target=0, out_pc=0, out_instr=0, out_illegal=0.
  - Reset mid-transfer drops all held entries.
- Data registers may be gated by their load enables. No X propagation is allowed on out_* while out_valid=1.
- Target adder is PC_W-bit modular; no overflow flag.

Test Plan:
- XLEN=32, I-type, instr 0xFFF00093, src 000, pc 0x0 -> next cycle out_valid=1, out_imm 0xFFFFFFFF, out_target 0xFFFFFFFF.
- XLEN=32, B-type beq -4, instr 0xFE000EE3, src 010, pc 0x100 -> out_imm 0xFFFFFFFC, out_target 0x000000FC.
- XLEN=32, J and U back to back, out_ready=1:
  - 0x0080006F, src 011, pc 0x200 -> imm 0x8, target 0x208.
  - then 0x123450B7, src 100 -> imm 0x12345000.
  - Both arrive on consecutive cycles, in order.
- Back-pressure: hold out_ready=0 and send 3 entries.
  - Expect in_ready=0 after 2 are accepted, the 3rd held upstream, and out_* stable.
  - Release out_ready: all 3 emerge in order with no gaps.
- XLEN=64:
  - 0xFFF00093, src 000 -> 0xFFFFFFFFFFFFFFFF.
  - lui 0x80000 (0x800000B7), src 100 -> 0xFFFFFFFF80000000.
  - slli shamt 33 (0x02109093), src 110 -> 0x21.
- Flush and illegal:
  - With both buffers full, assert flush for 1 cycle with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the flushed-cycle input is not seen.
  - src 111 -> out_imm 0, out_illegal=1.
  - rst_n low mid-stream -> out_valid=0 asynchronously.
